// File: rtl/usb_reg_arbiter.sv
// Two-requester arbiter in front of the usbHostSlave register port.
// A request is granted in IDLE, runs on the slave port in BUS, and is answered for one cycle in RESP.
module usb_reg_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req,
    input  logic [7:0] m0_addr,
    input  logic [7:0] m0_wdata,
    input  logic       m0_we,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,
    output logic       m0_err,
    input  logic       m1_req,
    input  logic [7:0] m1_addr,
    input  logic [7:0] m1_wdata,
    input  logic       m1_we,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic       m1_err,
    output logic [7:0] slv_addr,
    output logic [7:0] slv_wdata,
    output logic       slv_we,
    output logic       slv_strobe,
    input  logic [7:0] slv_rdata,
    input  logic       slv_ack,
    output logic [1:0] dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT      state, nextState;
    logic [7:0] waitCnt, waitCntNxt;
    logic       owner, ownerNxt;
    logic       lastGrant, lastGrantNxt;
    logic       pickM1, timedOut, busDone;
    logic [7:0] slvAddrNxt, slvWdataNxt;
    logic       slvWeNxt, slvStrobeNxt;
    logic       m0AckNxt, m1AckNxt, m0ErrNxt, m1ErrNxt;
    logic [7:0] m0RdataNxt, m1RdataNxt;
    logic [7:0] respRdata;
    logic       respErr;

    assign dbgState = state;
    assign timedOut = (waitCnt == TIMEOUT - 8'd1);
    // An ack in the final wait cycle still counts as a normal completion.
    assign busDone  = slv_ack || timedOut;
    // lastGrant==1 means m1 was served last, so m0 wins a tie.
    assign pickM1   = m1_req && (!m0_req || !lastGrant);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            waitCnt    <= 8'd0;
            owner      <= 1'b0;
            lastGrant  <= 1'b1;
            slv_addr   <= 8'd0;
            slv_wdata  <= 8'd0;
            slv_we     <= 1'b0;
            slv_strobe <= 1'b0;
            m0_ack     <= 1'b0;
            m0_rdata   <= 8'd0;
            m0_err     <= 1'b0;
            m1_ack     <= 1'b0;
            m1_rdata   <= 8'd0;
            m1_err     <= 1'b0;
        end else begin
            state      <= nextState;
            waitCnt    <= waitCntNxt;
            owner      <= ownerNxt;
            lastGrant  <= lastGrantNxt;
            slv_addr   <= slvAddrNxt;
            slv_wdata  <= slvWdataNxt;
            slv_we     <= slvWeNxt;
            slv_strobe <= slvStrobeNxt;
            m0_ack     <= m0AckNxt;
            m0_rdata   <= m0RdataNxt;
            m0_err     <= m0ErrNxt;
            m1_ack     <= m1AckNxt;
            m1_rdata   <= m1RdataNxt;
            m1_err     <= m1ErrNxt;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (m0_req || m1_req) nextState = BUS;
            BUS:     if (busDone) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Next values of every registered output, so outputs never glitch combinationally.
    always_comb begin
        waitCntNxt   = 8'd0;
        ownerNxt     = owner;
        lastGrantNxt = lastGrant;
        slvAddrNxt   = slv_addr;
        slvWdataNxt  = slv_wdata;
        slvWeNxt     = slv_we;
        slvStrobeNxt = (nextState == BUS);
        respRdata    = slv_ack ? slv_rdata : 8'd0;
        respErr      = !slv_ack;
        m0AckNxt     = 1'b0;
        m0RdataNxt   = 8'd0;
        m0ErrNxt     = 1'b0;
        m1AckNxt     = 1'b0;
        m1RdataNxt   = 8'd0;
        m1ErrNxt     = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    ownerNxt    = pickM1;
                    slvAddrNxt  = pickM1 ? m1_addr  : m0_addr;
                    slvWdataNxt = pickM1 ? m1_wdata : m0_wdata;
                    slvWeNxt    = pickM1 ? m1_we    : m0_we;
                end
            end
            BUS: begin
                if (busDone) begin
                    if (owner) begin
                        m1AckNxt   = 1'b1;
                        m1RdataNxt = respRdata;
                        m1ErrNxt   = respErr;
                    end else begin
                        m0AckNxt   = 1'b1;
                        m0RdataNxt = respRdata;
                        m0ErrNxt   = respErr;
                    end
                end else begin
                    waitCntNxt = waitCnt + 8'd1;
                end
            end
            RESP: lastGrantNxt = owner;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usb_reg_arbiter.sv
// Self-checking bench for usb_reg_arbiter: directed scenarios followed by random transactions
// checked against a transaction-level model of arbitration, timeout and response.
module tb_usb_reg_arbiter;

  localparam int TO = 4;

  logic       clk;
  logic       reset;
  logic       m0_req, m0_we, m0_ack, m0_err;
  logic [7:0] m0_addr, m0_wdata, m0_rdata;
  logic       m1_req, m1_we, m1_ack, m1_err;
  logic [7:0] m1_addr, m1_wdata, m1_rdata;
  logic [7:0] slv_addr, slv_wdata, slv_rdata;
  logic       slv_we, slv_strobe, slv_ack;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic last_gnt;
  int cyc;

  usb_reg_arbiter #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_we(slv_we), .slv_strobe(slv_strobe),
    .slv_rdata(slv_rdata), .slv_ack(slv_ack), .dbgState(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // One complete transaction, entered and left in IDLE. lat = BUS cycle index of the slave ack
  // (lat >= TO means the slave never answers inside the wait window).
  task automatic run_txn(input logic r0, input logic r1, input int lat, input logic [7:0] rd,
                         input logic [7:0] a0, input logic [7:0] d0, input logic we0,
                         input logic [7:0] a1, input logic [7:0] d1, input logic we1,
                         input bit drop_req, output int cycles);
    logic       exp_owner, e_we, e_err;
    logic [7:0] e_addr, e_data, e_rd;
    int         exp_strobe, n;
    exp_owner  = (r0 && r1) ? ~last_gnt : r1;
    e_addr     = exp_owner ? a1 : a0;
    e_data     = exp_owner ? d1 : d0;
    e_we       = exp_owner ? we1 : we0;
    e_err      = (lat >= TO);
    e_rd       = e_err ? 8'h00 : rd;
    exp_strobe = e_err ? TO : lat + 1;

    m0_req = r0; m0_addr = a0; m0_wdata = d0; m0_we = we0;
    m1_req = r1; m1_addr = a1; m1_wdata = d1; m1_we = we1;
    slv_ack = 1'($urandom_range(0, 1));
    slv_rdata = 8'($urandom);
    cycles = 0;
    n = 0;
    step(); cycles++;
    while (slv_strobe === 1'b1 && n < 16) begin
      check8("slv_addr", slv_addr, e_addr);
      check8("slv_wdata", slv_wdata, e_data);
      check1("slv_we", slv_we, e_we);
      check1("m0_ack_in_bus", m0_ack, 1'b0);
      check1("m1_ack_in_bus", m1_ack, 1'b0);
      if (drop_req) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      slv_ack = (n == lat);
      slv_rdata = (n == lat) ? rd : 8'($urandom);
      step(); cycles++; n++;
    end
    check8("strobe_cycles", 8'(n), 8'(exp_strobe));
    check1("m0_ack", m0_ack, ~exp_owner);
    check1("m1_ack", m1_ack, exp_owner);
    check8("m0_rdata", m0_rdata, exp_owner ? 8'h00 : e_rd);
    check8("m1_rdata", m1_rdata, exp_owner ? e_rd : 8'h00);
    check1("m0_err", m0_err, exp_owner ? 1'b0 : e_err);
    check1("m1_err", m1_err, exp_owner ? e_err : 1'b0);
    check1("strobe_in_resp", slv_strobe, 1'b0);
    m0_req = 1'b0;
    m1_req = 1'b0;
    slv_ack = 1'($urandom_range(0, 1));
    slv_rdata = 8'($urandom);
    step(); cycles++;
    check1("m0_ack_pulse", m0_ack, 1'b0);
    check1("m1_ack_pulse", m1_ack, 1'b0);
    check1("strobe_in_idle", slv_strobe, 1'b0);
    slv_ack = 1'b0;
    last_gnt = exp_owner;
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00; m0_we = 1'b0;
    m1_req = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00; m1_we = 1'b0;
    slv_rdata = 8'h00; slv_ack = 1'b0;
    last_gnt = 1'b1;

    // Reset state, with requests and slave ack toggling underneath.
    m0_req = 1'b1; m1_req = 1'b1; slv_ack = 1'b1;
    repeat (3) step();
    check1("rst_strobe", slv_strobe, 1'b0);
    check1("rst_m0_ack", m0_ack, 1'b0);
    check1("rst_m1_ack", m1_ack, 1'b0);
    check8("rst_slv_addr", slv_addr, 8'h00);
    check8("rst_slv_wdata", slv_wdata, 8'h00);
    check1("rst_slv_we", slv_we, 1'b0);
    check8("rst_m0_rdata", m0_rdata, 8'h00);
    check8("rst_m1_rdata", m1_rdata, 8'h00);
    check1("rst_m0_err", m0_err, 1'b0);
    check1("rst_m1_err", m1_err, 1'b0);
    check8("rst_state", {6'd0, dbg_state}, 8'h00);
    m0_req = 1'b0; m1_req = 1'b0; slv_ack = 1'b0;
    reset = 1'b0;

    // Both requesting from reset, immediate ack: m0, m1, m0, m1 in 3 cycles each.
    for (int k = 0; k < 4; k++) begin
      run_txn(1'b1, 1'b1, 0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0,
              8'($urandom), 8'($urandom), 1'b1, 1'b0, cyc);
      check8("txn_cycles", 8'(cyc), 8'd3);
      check1("alternate_owner", last_gnt, 1'(k % 2));
    end

    // m0 read of 0x05, slave answers in the 3rd BUS cycle.
    run_txn(1'b1, 1'b0, 2, 8'hA5, 8'h05, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, cyc);
    // m1 write of 0x3C to 0x10, request dropped during BUS.
    run_txn(1'b0, 1'b1, 1, 8'h77, 8'h00, 8'h00, 1'b0, 8'h10, 8'h3C, 1'b1, 1'b1, cyc);
    // Slave never acks: timeout after TO strobe cycles.
    run_txn(1'b1, 1'b0, 100, 8'hEE, 8'h21, 8'h43, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, cyc);
    run_txn(1'b0, 1'b1, 100, 8'hEE, 8'h00, 8'h00, 1'b0, 8'h22, 8'h44, 1'b1, 1'b0, cyc);
    // Ack in the last wait cycle wins over the timeout.
    run_txn(1'b0, 1'b1, TO - 1, 8'h5A, 8'h00, 8'h00, 1'b0, 8'h31, 8'h00, 1'b0, 1'b0, cyc);
    run_txn(1'b1, 1'b0, TO - 1, 8'hC3, 8'h32, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, cyc);

    // Reset in the 2nd BUS cycle; last grant was m0, so without reset the next tie would go to m1.
    m1_req = 1'b1; m1_addr = 8'h66;
    step();
    check1("abort_bus1_strobe", slv_strobe, 1'b1);
    step();
    check1("abort_bus2_strobe", slv_strobe, 1'b1);
    m1_req = 1'b0;
    reset = 1'b1;
    step();
    check1("abort_strobe", slv_strobe, 1'b0);
    check1("abort_m0_ack", m0_ack, 1'b0);
    check1("abort_m1_ack", m1_ack, 1'b0);
    reset = 1'b0;
    last_gnt = 1'b1;
    slv_ack = 1'b1;
    step();
    check1("abort_m0_ack_after", m0_ack, 1'b0);
    check1("abort_m1_ack_after", m1_ack, 1'b0);
    check1("abort_strobe_after", slv_strobe, 1'b0);
    slv_ack = 1'b0;
    run_txn(1'b1, 1'b1, 0, 8'h99, 8'h01, 8'h02, 1'b1, 8'h03, 8'h04, 1'b0, 1'b0, cyc);
    check1("tie_after_reset_m0", last_gnt, 1'b0);

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      logic r0, r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      run_txn(r0, r1, int'($urandom_range(0, 6)), 8'($urandom),
              8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
              bit'($urandom_range(0, 1)), cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_reg_arbiter.md
USB_REG_ARBITER -- requirements
Module: usb_reg_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8'd64: the maximum number of BUS-state cycles to wait for slv_ack, legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port m0_req, input, 1 bit: requester 0 access request, held until m0_ack.
REQ-005 The block SHALL have port m0_addr, input, 8 bits: requester 0 register address.
REQ-006 The block SHALL have port m0_wdata, input, 8 bits: requester 0 write data.
REQ-007 The block SHALL have port m0_we, input, 1 bit: requester 0 write enable (1 = write, 0 = read).
REQ-008 The block SHALL have port m0_ack, output, 1 bit: one-cycle completion pulse to requester 0.
REQ-009 The block SHALL have port m0_rdata, output, 8 bits: requester 0 read data, valid while m0_ack is high.
REQ-010 The block SHALL have port m0_err, output, 1 bit: timeout flag, valid while m0_ack is high.
REQ-011 The block SHALL have requester 1 ports m1_req, m1_addr, m1_wdata, m1_we, m1_ack, m1_rdata, m1_err, identical in direction, width and meaning to the m0_* ports.
REQ-012 The block SHALL have output ports slv_addr (8 bits), slv_wdata (8 bits), slv_we (1 bit) and slv_strobe (1 bit), driving the usbHostSlave register port.
REQ-013 The block SHALL have input ports slv_rdata (8 bits) and slv_ack (1 bit), returned from the usbHostSlave register port.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, BUS and RESP, and all outputs SHALL be registered.
REQ-015 In IDLE, if any request is high, the block SHALL select one requester, latch its addr, wdata and we onto the slv_* outputs, record the owner, and enter BUS on the next cycle.
REQ-016 When both requests are high in the same IDLE cycle, the block SHALL grant the requester that was not the last one granted; after reset, requester 0 SHALL win the first tie.
REQ-017 slv_strobe SHALL be 1 exactly while the state is BUS, and slv_addr, slv_wdata and slv_we SHALL remain stable throughout BUS.
REQ-018 In BUS, when slv_ack=1 is sampled, the block SHALL capture slv_rdata, set err=0, and enter RESP on the next cycle.
REQ-019 In BUS, a wait counter SHALL increment by 1 each cycle, starting from 0 on BUS entry.
REQ-020 If the wait counter reaches TIMEOUT-1 without slv_ack, the block SHALL enter RESP with err=1 and rdata=8'h00.
REQ-021 If slv_ack arrives in the same cycle the counter reaches TIMEOUT-1, the ack SHALL win (err=0).
REQ-022 In RESP, only the owner's ack SHALL be 1, with rdata and err driven for that owner; the non-owner's ack, rdata and err SHALL be 0.
REQ-023 The block SHALL leave RESP for IDLE unconditionally after one cycle, and the last-granted record SHALL update to the owner at that transition.
REQ-024 The minimum transaction, with slv_ack in the first BUS cycle, SHALL be IDLE (sample request), BUS, RESP: ack appears 2 cycles after the request is sampled.
REQ-025 A request deasserted while the state is BUS SHALL NOT abort the transaction; the block SHALL complete it and return ack normally.
REQ-026 slv_ack sampled in IDLE or RESP SHALL be ignored.
REQ-027 The block SHALL be capable of back-to-back grants: the IDLE cycle following RESP arbitrates again, so a continuously requesting pair alternates.

Reset
REQ-028 On reset=1, the block SHALL enter IDLE, set the last-granted record to 1 (so m0 wins the first tie), clear the wait counter, and drive all outputs to 0.
REQ-029 Reset asserted during BUS or RESP SHALL abandon the transaction with no ack issued, and slv_strobe SHALL be 0 on the next cycle.

Verification
REQ-030 The bench SHALL cover: m0 read of addr 8'h05, slave acks after 3 BUS cycles with slv_rdata=8'hA5 -> m0_ack pulse of 1 cycle, m0_rdata=8'hA5, m0_err=0, and m1_ack stays 0.
REQ-031 The bench SHALL cover: m0_req and m1_req both high from reset, with immediate slave ack -> grants in the order m0, m1, m0, m1, and each transaction is 3 cycles.
REQ-032 The bench SHALL cover: m1 write of addr 8'h10 with wdata 8'h3C -> slv_we=1, slv_addr=8'h10 and slv_wdata=8'h3C held stable for every strobe cycle.
REQ-033 The bench SHALL cover: TIMEOUT=4 with the slave never acking -> strobe high exactly 4 cycles, then the owner's ack=1 with err=1 and rdata=8'h00.
REQ-034 The bench SHALL cover: TIMEOUT=4 with slv_ack on the 4th BUS cycle -> err=0 and rdata captured.
REQ-035 The bench SHALL cover: reset asserted in the 2nd BUS cycle -> next cycle slv_strobe=0, no ack on either requester, and the next tie is granted to m0.
